// File: rtl/soc_mem_arbiter_if.sv
// soc_mem_arbiter_if: one Wishbone link; the master modport drives requests, the slave modport answers
interface soc_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   wdat;
  logic [DW-1:0]   rdat;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic            err;
  logic            rty;
  modport master (output adr, wdat, sel, we, cyc, stb, input rdat, ack, err, rty);
  modport slave  (input adr, wdat, sel, we, cyc, stb, output rdat, ack, err, rty);
endinterface

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: round-robin two-master Wishbone arbiter in front of one memory bank,
// holding the grant for the whole bus cycle, with a watchdog that errors out stalled strobes
module soc_mem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic               mem_clk,
  input  logic               mem_rst_n,
  soc_mem_arbiter_if.slave   m0,
  soc_mem_arbiter_if.slave   m1,
  soc_mem_arbiter_if.master  s
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [TW-1:0] wd_q;
  logic          own0, own1, cyc_x, stb_x, stalled, wd_fire;
  assign own0    = state_q == OWN0;
  assign own1    = state_q == OWN1;
  assign cyc_x   = own1 ? m1.cyc : own0 & m0.cyc;
  assign stb_x   = own1 ? m1.stb : own0 & m0.stb;
  assign stalled = stb_x & ~s.ack & ~s.err & ~s.rty;
  assign wd_fire = TIMEOUT > 0 && stalled && wd_q == WD_LAST;
  // Idle and M0-owned cycles both route M0's address/data; only cyc/stb qualify them
  assign s.adr   = own1 ? m1.adr  : m0.adr;
  assign s.wdat  = own1 ? m1.wdat : m0.wdat;
  assign s.sel   = own1 ? m1.sel  : m0.sel;
  assign s.we    = own1 ? m1.we   : m0.we;
  assign s.cyc   = cyc_x;
  assign s.stb   = cyc_x & stb_x & ~wd_fire;
  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;
  assign m0.ack  = own0 & s.ack;
  assign m1.ack  = own1 & s.ack;
  assign m0.err  = own0 & (s.err | wd_fire);
  assign m1.err  = own1 & (s.err | wd_fire);
  assign m0.rty  = own0 & s.rty;
  assign m1.rty  = own1 & s.rty;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (state_q == IDLE)
      state_d = (m0.cyc && (!m1.cyc || last_q)) ? OWN0 : m1.cyc ? OWN1 : IDLE;
    else if (!cyc_x) begin
      last_d  = own1;
      state_d = (own1 ? m0.cyc : m1.cyc) ? (own1 ? OWN0 : OWN1) : IDLE;
    end
  end
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= (TIMEOUT == 0 || state_d != state_q || !stalled || wd_fire) ? '0 : wd_q + 1'b1;
    end
  end
endmodule
